// File: rtl/tpu_seq_ctrl_if.sv
// Control/status bundle between a tile scheduler and the TPU sequencing controller.
// The master side requests passes and models the weight FIFO flag; the slave side
// is the controller that issues FIFO pops, weight reloads and UB read addresses.
interface tpu_seq_ctrl_if #(
  parameter int ADDRESSSIZE = 10
);
  logic                   start;
  logic                   abort;
  logic [ADDRESSSIZE-1:0] base_addr;
  logic [ADDRESSSIZE-1:0] num_rows;
  logic                   fifo_empty;
  logic                   fifo_read_enable;
  logic                   we_rl;
  logic [ADDRESSSIZE-1:0] sram_address;
  logic                   addr_valid;
  logic                   result_valid;
  logic                   busy;
  logic                   end_;

  modport master (
    output start,
    output abort,
    output base_addr,
    output num_rows,
    output fifo_empty,
    input  fifo_read_enable,
    input  we_rl,
    input  sram_address,
    input  addr_valid,
    input  result_valid,
    input  busy,
    input  end_
  );

  modport slave (
    input  start,
    input  abort,
    input  base_addr,
    input  num_rows,
    input  fifo_empty,
    output fifo_read_enable,
    output we_rl,
    output sram_address,
    output addr_valid,
    output result_valid,
    output busy,
    output end_
  );
endinterface

// File: rtl/tpu_seq_ctrl.sv
// TPU tile-pass sequencer: waits for a weight tile in the FIFO, pops it, pulses the
// systolic weight reload, streams num_rows activation addresses out of the UB and
// then drains the array pipeline so that every aligned result row has emerged
// before signalling the end of the pass.
module tpu_seq_ctrl #(
  parameter int ADDRESSSIZE = 10,
  parameter int PIPE_LAT    = 17
) (
  input  logic             clk,
  input  logic             rstn,
  tpu_seq_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_W,
    RELOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // Drain counter only has to reach PIPE_LAT-1.
  localparam int                     CNT_W      = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CNT_W-1:0]       DRAIN_LAST = CNT_W'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
  localparam logic [ADDRESSSIZE-1:0] ADDR_ONE   = ADDRESSSIZE'(1);
  localparam logic [ADDRESSSIZE-1:0] ADDR_ZERO  = '0;

  state_t                 state;
  logic [ADDRESSSIZE-1:0] base_q;
  logic [ADDRESSSIZE-1:0] rows_q;
  logic [ADDRESSSIZE-1:0] row_k;
  logic [ADDRESSSIZE-1:0] sram_address_q;
  logic [CNT_W-1:0]       drain_cnt;
  logic [PIPE_LAT-1:0]    delay_line;
  logic                   we_rl_q;
  logic                   addr_valid_q;
  logic                   busy_q;
  logic                   end_q;

  logic                   abort_hit;
  logic                   last_row;

  // Abort only means something while a pass is in flight.
  assign abort_hit = bus.abort && (state != IDLE);
  assign last_row  = (row_k == (rows_q - ADDR_ONE));

  // The FIFO pop is combinational so the tile leaves the FIFO in the very cycle
  // it is seen; a concurrent abort suppresses it so a cancelled pass never pops.
  assign bus.fifo_read_enable = (state == WAIT_W) && !bus.fifo_empty && !bus.abort;

  assign bus.we_rl        = we_rl_q;
  assign bus.sram_address = sram_address_q;
  assign bus.addr_valid   = addr_valid_q;
  assign bus.result_valid = delay_line[PIPE_LAT-1];
  assign bus.busy         = busy_q;
  assign bus.end_         = end_q;

  // Pass sequencing FSM with all pulse/level outputs registered alongside the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      base_q         <= ADDR_ZERO;
      rows_q         <= ADDR_ZERO;
      row_k          <= ADDR_ZERO;
      sram_address_q <= ADDR_ZERO;
      drain_cnt      <= '0;
      we_rl_q        <= 1'b0;
      addr_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      end_q          <= 1'b0;
    end else begin
      we_rl_q <= 1'b0;
      end_q   <= 1'b0;
      if (abort_hit) begin
        state        <= IDLE;
        addr_valid_q <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              busy_q <= 1'b1;
              if (bus.num_rows != ADDR_ZERO) begin
                base_q <= bus.base_addr;
                rows_q <= bus.num_rows;
                state  <= WAIT_W;
              end else begin
                state <= DONE;
                end_q <= 1'b1;
              end
            end
          end
          WAIT_W: begin
            if (!bus.fifo_empty) begin
              state   <= RELOAD;
              we_rl_q <= 1'b1;
            end
          end
          RELOAD: begin
            state          <= STREAM;
            row_k          <= ADDR_ZERO;
            sram_address_q <= base_q;
            addr_valid_q   <= 1'b1;
          end
          STREAM: begin
            if (last_row) begin
              state        <= DRAIN;
              addr_valid_q <= 1'b0;
              drain_cnt    <= '0;
            end else begin
              row_k          <= row_k + ADDR_ONE;
              sram_address_q <= base_q + row_k + ADDR_ONE;
            end
          end
          DRAIN: begin
            if (drain_cnt == DRAIN_LAST) begin
              state <= DONE;
              end_q <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + CNT_ONE;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state        <= IDLE;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        endcase
      end
    end
  end

  // Delay line that re-times each live address into its aligned result row.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      delay_line <= '0;
    end else if (abort_hit) begin
      delay_line <= '0;
    end else begin
      delay_line <= (delay_line << 1) | PIPE_LAT'(addr_valid_q);
    end
  end

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Scoreboard bench for tpu_seq_ctrl: each start pushes the expected timed event
// stream (pop, reload, addresses, result rows, end pulse) into a queue and an
// independent negedge monitor matches every DUT event against it.
module tb_tpu_seq_ctrl;

  localparam int AW = 10;
  localparam int P  = 17;

  localparam int EV_FRE  = 0;
  localparam int EV_WE   = 1;
  localparam int EV_ADDR = 2;
  localparam int EV_RES  = 3;
  localparam int EV_END  = 4;

  typedef struct {
    int          kind;
    int          cyc;
    logic [AW-1:0] addr;
  } ev_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ev_t  expq[$];

  tpu_seq_ctrl_if #(.ADDRESSSIZE(AW)) bus ();

  tpu_seq_ctrl #(
    .ADDRESSSIZE(AW),
    .PIPE_LAT   (P)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  // Free-running clock and cycle stamp shared by stimulus and monitor.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(int kind);
    case (kind)
      EV_FRE:  return "fifo_read_enable";
      EV_WE:   return "we_rl";
      EV_ADDR: return "addr_valid";
      EV_RES:  return "result_valid";
      default: return "end_";
    endcase
  endfunction

  task automatic push_ev(int kind, int t, logic [AW-1:0] a);
    ev_t e;
    e.kind = kind;
    e.cyc  = t;
    e.addr = a;
    expq.push_back(e);
  endtask

  // Expected event stream of one pass accepted at cycle s, with w empty-FIFO
  // cycles; events at or after cutoff are discarded by abort/reset.
  task automatic push_pass(int s, int w, logic [AW-1:0] base, int rows, int cutoff);
    int t_fre;
    int t_we;
    int t_a0;
    int t_end;
    logic [AW-1:0] a;
    if (rows == 0) begin
      if (s < cutoff) push_ev(EV_END, s, '0);
      return;
    end
    t_fre = s + w;
    t_we  = t_fre + 1;
    t_a0  = t_we + 1;
    t_end = t_a0 + rows + P;
    for (int t = s; t <= t_end; t++) begin
      if (t >= cutoff) break;
      if (t == t_fre) push_ev(EV_FRE, t, '0);
      if (t == t_we) push_ev(EV_WE, t, '0);
      if (t >= t_a0 && t < t_a0 + rows) begin
        a = AW'(int'(base) + (t - t_a0));
        push_ev(EV_ADDR, t, a);
      end
      if (t >= t_a0 + P && t < t_a0 + rows + P) push_ev(EV_RES, t, '0);
      if (t == t_end) push_ev(EV_END, t, '0);
    end
  endtask

  task automatic observe(int kind, logic [AW-1:0] a, int now);
    int idx;
    idx = -1;
    for (int i = 0; i < expq.size() && expq[i].cyc == now; i++) begin
      if (expq[i].kind == kind) begin
        idx = i;
        break;
      end
    end
    vectors++;
    if (idx < 0) begin
      miscompares++;
      $display("[TB] FAIL unexpected_%s cyc %0d: actual 1, required 0", kind_name(kind), now);
    end else begin
      if (kind == EV_ADDR && expq[idx].addr != a) begin
        miscompares++;
        $display("[TB] FAIL sram_address cyc %0d: actual %0d, required %0d", now, a, expq[idx].addr);
      end
      expq.delete(idx);
    end
  endtask

  // Monitor: flags overdue expectations, then matches every event the DUT shows.
  always @(negedge clk) begin
    while (expq.size() > 0 && expq[0].cyc < cyc) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL missing_%s cyc %0d: actual 0, required 1", kind_name(expq[0].kind), expq[0].cyc);
      void'(expq.pop_front());
    end
    if (bus.fifo_read_enable) observe(EV_FRE, '0, cyc);
    if (bus.we_rl) observe(EV_WE, '0, cyc);
    if (bus.addr_valid) observe(EV_ADDR, bus.sram_address, cyc);
    if (bus.result_valid) observe(EV_RES, '0, cyc);
    if (bus.end_) observe(EV_END, '0, cyc);
  end

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s cyc %0d: actual %0d, required %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int t);
    while (cyc < t) tick();
  endtask

  // Issues one start; returns the cycle in which the pass is first visible.
  task automatic applyStimulus(logic [AW-1:0] base, int rows, int w, int cut_off, output int s);
    s = cyc + 1;
    push_pass(s, w, base, rows, (cut_off < 0) ? 32'h7fff_ffff : s + cut_off);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.num_rows  = AW'(rows);
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int s2;
    rstn           = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.base_addr  = '0;
    bus.num_rows   = '0;
    bus.fifo_empty = 1'b0;
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_end", 32'(bus.end_), 0);
    checkOutput("rst_we_rl", 32'(bus.we_rl), 0);
    checkOutput("rst_addr_valid", 32'(bus.addr_valid), 0);
    checkOutput("rst_result_valid", 32'(bus.result_valid), 0);
    checkOutput("rst_sram_address", 32'(bus.sram_address), 0);

    $display("[TB] base 16 rows 4, start on first edge after reset release");
    rstn = 1'b1;
    applyStimulus(10'd16, 4, 0, -1, s);
    bus.base_addr = 10'd500;
    bus.num_rows  = 10'd9;
    checkOutput("busy_wait_w", 32'(bus.busy), 1);
    wait_until(s + 26);
    checkOutput("idle_busy", 32'(bus.busy), 0);
    checkOutput("hold_sram_address", 32'(bus.sram_address), 19);
    checkOutput("sb_empty_basic", 32'(expq.size()), 0);

    $display("[TB] weight FIFO empty for 5 cycles");
    bus.fifo_empty = 1'b1;
    applyStimulus(10'd100, 3, 5, -1, s);
    wait_until(s + 3);
    checkOutput("busy_fifo_wait", 32'(bus.busy), 1);
    wait_until(s + 5);
    bus.fifo_empty = 1'b0;
    wait_until(s + 5 + 2 + 3 + P + 3);
    checkOutput("sb_empty_fifo", 32'(expq.size()), 0);

    $display("[TB] address wrap base 1020 rows 6, start during DONE");
    applyStimulus(10'd1020, 6, 0, -1, s);
    wait_until(s + 25);
    bus.start     = 1'b1;
    bus.base_addr = 10'd300;
    bus.num_rows  = 10'd5;
    tick();
    bus.start = 1'b0;
    wait_until(s + 32);
    checkOutput("wrap_hold_sram_address", 32'(bus.sram_address), 1);
    checkOutput("sb_empty_wrap", 32'(expq.size()), 0);

    $display("[TB] zero rows");
    applyStimulus(10'd77, 0, 0, -1, s);
    checkOutput("zero_busy_done", 32'(bus.busy), 1);
    tick();
    checkOutput("zero_busy_idle", 32'(bus.busy), 0);
    checkOutput("zero_sram_address", 32'(bus.sram_address), 1);
    wait_until(s + 4);
    checkOutput("sb_empty_zero", 32'(expq.size()), 0);

    $display("[TB] abort in STREAM at k=2, then full pass");
    applyStimulus(10'd40, 8, 0, 5, s);
    wait_until(s + 4);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("abort_busy", 32'(bus.busy), 0);
    checkOutput("abort_addr_valid", 32'(bus.addr_valid), 0);
    wait_until(s + 30);
    checkOutput("sb_empty_abort", 32'(expq.size()), 0);
    applyStimulus(10'd50, 2, 0, -1, s2);
    wait_until(s2 + 24);
    checkOutput("after_abort_sram_address", 32'(bus.sram_address), 51);
    checkOutput("sb_empty_after_abort", 32'(expq.size()), 0);

    $display("[TB] reset during DRAIN, start pulsed in STREAM");
    applyStimulus(10'd200, 4, 0, 8, s);
    wait_until(s + 3);
    bus.start     = 1'b1;
    bus.base_addr = 10'd600;
    bus.num_rows  = 10'd3;
    tick();
    bus.start = 1'b0;
    wait_until(s + 8);
    rstn = 1'b0;
    #1;
    checkOutput("drain_rst_busy", 32'(bus.busy), 0);
    checkOutput("drain_rst_addr_valid", 32'(bus.addr_valid), 0);
    checkOutput("drain_rst_result_valid", 32'(bus.result_valid), 0);
    checkOutput("drain_rst_sram_address", 32'(bus.sram_address), 0);
    checkOutput("drain_rst_end", 32'(bus.end_), 0);
    tick();
    tick();
    rstn = 1'b1;
    applyStimulus(10'd7, 1, 0, -1, s2);
    wait_until(s2 + 25);
    checkOutput("post_rst_sram_address", 32'(bus.sram_address), 7);
    checkOutput("sb_empty_final", 32'(expq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tpu_seq_ctrl.md
TPU_SEQ_CTRL -- requirements
Module: tpu_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDRESSSIZE, default 10, UB address width.
REQ-002 SHALL have parameter PIPE_LAT, default 17, cycles from an issued UB address to its aligned result row.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request one tile pass; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1, synchronous cancel of the current pass.
REQ-007 SHALL have port base_addr, input, ADDRESSSIZE, first activation word address; latched on accepted start.
REQ-008 SHALL have port num_rows, input, ADDRESSSIZE, activation vectors to stream; latched on accepted start.
REQ-009 SHALL have port fifo_empty, input, 1, weight FIFO empty flag.
REQ-010 SHALL have port fifo_read_enable, output, 1, weight FIFO pop strobe.
REQ-011 SHALL have port we_rl, output, 1, systolic weight-reload pulse.
REQ-012 SHALL have port sram_address, output, ADDRESSSIZE, UB read address.
REQ-013 SHALL have port addr_valid, output, 1, sram_address carries a live activation read.
REQ-014 SHALL have port result_valid, output, 1, aligned result row present this cycle.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 SHALL have port end_, output, 1, one-cycle pass-complete pulse.

Function
REQ-017 SHALL implement states IDLE, WAIT_W, RELOAD, STREAM, DRAIN, DONE.
REQ-018 IDLE: start=1 and num_rows!=0 -> latch base_addr/num_rows, next WAIT_W; start=1 and num_rows=0 -> next DONE, no FIFO pop, no we_rl.
REQ-019 WAIT_W: fifo_read_enable = !fifo_empty (combinational); stay while fifo_empty=1, indefinitely; on fifo_empty=0 next RELOAD.
REQ-020 RELOAD: we_rl=1 for exactly this one cycle; next STREAM.
REQ-021 STREAM: addr_valid=1, sram_address=base+k for k=0..num_rows-1, one per cycle, k reset to 0 on STREAM entry; after k=num_rows-1 next DRAIN.
REQ-022 Address arithmetic SHALL be modulo 2^ADDRESSSIZE (base 1020, 6 rows -> 1020,1021,1022,1023,0,1).
REQ-023 sram_address SHALL hold its last value outside STREAM; 0 after reset.
REQ-024 result_valid SHALL equal addr_valid delayed exactly PIPE_LAT cycles (shift register, cleared by reset and abort).
REQ-025 DRAIN: count PIPE_LAT cycles; the last result_valid SHALL occur in the final DRAIN cycle; next DONE.
REQ-026 DONE: end_=1 for one cycle; next IDLE; start in DONE ignored.
REQ-027 start outside IDLE SHALL be ignored; base_addr/num_rows changes after latching SHALL have no effect.
REQ-028 abort=1 in any non-IDLE state: next state IDLE, no end_, delay line cleared, fifo_read_enable forced 0 that cycle; abort has priority over all transitions; abort in IDLE has no effect.
REQ-029 fifo_read_enable and we_rl SHALL each assert at most once per pass.

Reset
REQ-030 rstn=0 SHALL asynchronously force IDLE; fifo_read_enable, we_rl, addr_valid, result_valid, busy, end_ = 0; sram_address, k, drain counter, delay line = 0.
REQ-031 After rstn release, first possible start acceptance SHALL be the first rising edge with rstn=1.
REQ-032 Reset mid-pass SHALL discard the pass; no end_ issued.

Verification
REQ-033 base=16, rows=4, FIFO non-empty: start -> WAIT_W 1 cycle with fifo_read_enable=1, we_rl 1 cycle, addresses 16..19, result_valid 4 cycles starting 17 after first address, end_ 1 cycle after last DRAIN cycle.
REQ-034 FIFO empty 5 cycles after start: WAIT_W held 5 cycles, fifo_read_enable=0 throughout, pops on cycle 6, then normal sequence.
REQ-035 base=1020, rows=6: addresses 1020..1023,0,1; end_ once.
REQ-036 rows=0: start -> DONE next cycle, end_ pulse, no fifo_read_enable, no we_rl, no addr_valid.
REQ-037 abort during STREAM at k=2: next cycle IDLE, busy=0, no further result_valid, no end_; new start then runs a full pass.
REQ-038 rstn low during DRAIN: outputs 0 immediately, no end_; start pulsed in STREAM ignored.
